hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_pkg.sv | 18 +
 rtl/md_scoreboard.sv | 69 ++++++
 rtl/hazard_ctrl.sv | 98 +++++++++
 tb/tb_hazard_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller.
package hazard_pkg;

    // Operand source select for one execute-stage read port.
    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    // Multi-cycle (mul/div) unit occupancy.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        WB   = 2'b10
    } md_state_t;

endpackage

// File: rtl/md_scoreboard.sv
// Tracks the single in-flight multi-cycle op: its destination and when it writes back.
module md_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned AW     = 5,
    parameter int unsigned MD_LAT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mdStartE,
    input  logic [AW-1:0] rdE,
    output logic          mdBusy,
    output logic          mdWbValid,
    output logic [AW-1:0] mdWbRd,
    output logic [AW-1:0] mdRd
);

    localparam int unsigned CW = $clog2(MD_LAT);

    md_state_t     state;
    logic [CW-1:0] cnt;

    // Occupancy FSM; outputs are registered alongside the state so they follow it exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            mdRd      <= '0;
            mdBusy    <= 1'b0;
            mdWbValid <= 1'b0;
            mdWbRd    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // A start while not idle is dropped; decode stalls keep legal streams from doing it.
                    if (mdStartE) begin
                        state  <= BUSY;
                        cnt    <= CW'(MD_LAT - 2);
                        mdRd   <= rdE;
                        mdBusy <= 1'b1;
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        state     <= WB;
                        mdWbValid <= 1'b1;
                        mdWbRd    <= mdRd;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                WB: begin
                    state     <= IDLE;
                    mdBusy    <= 1'b0;
                    mdWbValid <= 1'b0;
                    mdWbRd    <= '0;
                end
                default: begin
                    state     <= IDLE;
                    cnt       <= '0;
                    mdBusy    <= 1'b0;
                    mdWbValid <= 1'b0;
                    mdWbRd    <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Forwarding selects and stall/flush control for a 5-stage pipeline with one multi-cycle unit.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned NREAD  = 2,
    parameter int unsigned AW     = 5,
    parameter int unsigned MD_LAT = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREAD-1:0][AW-1:0]   rsD,
    input  logic [AW-1:0]              rdD,
    input  logic                       regWriteD,
    input  logic                       mdOpD,
    input  logic [NREAD-1:0][AW-1:0]   rsE,
    input  logic [AW-1:0]              rdE,
    input  logic                       memReadE,
    input  logic                       pcSrcE,
    input  logic                       mdStartE,
    input  logic [AW-1:0]              rdM,
    input  logic                       regWriteM,
    input  logic [AW-1:0]              rdW,
    input  logic                       regWriteW,
    output logic [NREAD-1:0][1:0]      fwdE,
    output logic                       stallF,
    output logic                       stallD,
    output logic                       flushD,
    output logic                       flushE,
    output logic                       mdBusy,
    output logic                       mdWbValid,
    output logic [AW-1:0]              mdWbRd
);

    logic [AW-1:0] mdRd;
    logic          hit_e;
    logic          hit_md;
    logic          load_use;
    logic          md_haz;

    md_scoreboard #(
        .AW     (AW),
        .MD_LAT (MD_LAT)
    ) u_md_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .mdStartE  (mdStartE),
        .rdE       (rdE),
        .mdBusy    (mdBusy),
        .mdWbValid (mdWbValid),
        .mdWbRd    (mdWbRd),
        .mdRd      (mdRd)
    );

    // Per-port bypass select; the younger memory-stage result beats writeback.
    always_comb begin
        fwdE = '0;
        for (int i = 0; i < NREAD; i++) begin
            if (regWriteM && (rdM != '0) && (rsE[i] == rdM)) begin
                fwdE[i] = FWD_M;
            end else if (regWriteW && (rdW != '0) && (rsE[i] == rdW)) begin
                fwdE[i] = FWD_W;
            end else begin
                fwdE[i] = FWD_RF;
            end
        end
    end

    // Hazard detection: load-use, pending multi-cycle destination, and structural busy.
    always_comb begin
        hit_e  = 1'b0;
        hit_md = 1'b0;
        for (int i = 0; i < NREAD; i++) begin
            if (rsD[i] == rdE)  hit_e  = 1'b1;
            if (rsD[i] == mdRd) hit_md = 1'b1;
        end
        load_use = memReadE && (rdE != '0) && hit_e;
        md_haz   = (mdBusy && (mdRd != '0) && (hit_md || (regWriteD && (rdD == mdRd))))
                 || (mdBusy && mdOpD)
                 || (mdStartE && (rdE != '0) && hit_e);
    end

    // A taken branch squashes the younger stages and overrides any stall.
    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        if (pcSrcE) begin
            flushD = 1'b1;
            flushE = 1'b1;
        end else if (load_use || md_haz) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench: a default instance (NREAD=2, MD_LAT=4) and a swept one (NREAD=3, MD_LAT=2).
module tb_hazard_ctrl;

    localparam int unsigned AW = 5;

    logic                clk;
    logic                rst;
    logic [2:0][AW-1:0]  rsD;
    logic [2:0][AW-1:0]  rsE;
    logic [AW-1:0]       rdD, rdE, rdM, rdW;
    logic                regWriteD, mdOpD, memReadE, pcSrcE, mdStartE, regWriteM, regWriteW;

    logic [1:0][1:0]     a_fwdE;
    logic                a_stallF, a_stallD, a_flushD, a_flushE, a_mdBusy, a_mdWbValid;
    logic [AW-1:0]       a_mdWbRd;
    logic [2:0][1:0]     b_fwdE;
    logic                b_stallF, b_stallD, b_flushD, b_flushE, b_mdBusy, b_mdWbValid;
    logic [AW-1:0]       b_mdWbRd;

    hazard_ctrl #(.NREAD(2), .AW(AW), .MD_LAT(4)) u_a (
        .clk(clk), .rst(rst), .rsD(rsD[1:0]), .rdD(rdD), .regWriteD(regWriteD), .mdOpD(mdOpD),
        .rsE(rsE[1:0]), .rdE(rdE), .memReadE(memReadE), .pcSrcE(pcSrcE), .mdStartE(mdStartE),
        .rdM(rdM), .regWriteM(regWriteM), .rdW(rdW), .regWriteW(regWriteW),
        .fwdE(a_fwdE), .stallF(a_stallF), .stallD(a_stallD), .flushD(a_flushD), .flushE(a_flushE),
        .mdBusy(a_mdBusy), .mdWbValid(a_mdWbValid), .mdWbRd(a_mdWbRd)
    );

    hazard_ctrl #(.NREAD(3), .AW(AW), .MD_LAT(2)) u_b (
        .clk(clk), .rst(rst), .rsD(rsD), .rdD(rdD), .regWriteD(regWriteD), .mdOpD(mdOpD),
        .rsE(rsE), .rdE(rdE), .memReadE(memReadE), .pcSrcE(pcSrcE), .mdStartE(mdStartE),
        .rdM(rdM), .regWriteM(regWriteM), .rdW(rdW), .regWriteW(regWriteW),
        .fwdE(b_fwdE), .stallF(b_stallF), .stallD(b_stallD), .flushD(b_flushD), .flushE(b_flushE),
        .mdBusy(b_mdBusy), .mdWbValid(b_mdWbValid), .mdWbRd(b_mdWbRd)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: one op record per instance (active flag, dest, cycle of its writeback).
    int            ncmp;
    int            nfail;
    int            cyc;
    bit            m_act   [2];
    logic [AW-1:0] m_rd    [2];
    int            m_wb_at [2];

    function automatic int nread_of(input int d);
        return (d == 0) ? 2 : 3;
    endfunction

    function automatic int lat_of(input int d);
        return (d == 0) ? 4 : 2;
    endfunction

    task automatic cmp(input string tag, input string fld, input int d,
                       input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s/%s dut%0d: observed %0h expected %0h", tag, fld, d, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [2:0][1:0] ef, of;
        logic            e_hit, m_hit, lu, md, haz, wbv;
        logic [5:0]      oc;
        logic [AW-1:0]   owr;
        if (rst) begin
            m_act[0] = 1'b0;
            m_act[1] = 1'b0;
        end
        for (int d = 0; d < 2; d++) begin
            ef    = '0;
            e_hit = 1'b0;
            m_hit = 1'b0;
            for (int i = 0; i < nread_of(d); i++) begin
                if (regWriteM && rdM != 0 && rsE[i] == rdM)      ef[i] = 2'b10;
                else if (regWriteW && rdW != 0 && rsE[i] == rdW) ef[i] = 2'b01;
                if (rsD[i] == rdE)      e_hit = 1'b1;
                if (rsD[i] == m_rd[d])  m_hit = 1'b1;
            end
            lu  = memReadE && rdE != 0 && e_hit;
            md  = (m_act[d] && m_rd[d] != 0 && (m_hit || (regWriteD && rdD == m_rd[d])))
                  || (m_act[d] && mdOpD)
                  || (mdStartE && rdE != 0 && e_hit);
            haz = lu || md;
            wbv = m_act[d] && (cyc == m_wb_at[d]);
            of  = '0;
            if (d == 0) begin
                of[1:0] = a_fwdE;
                oc  = {a_stallF, a_stallD, a_flushD, a_flushE, a_mdBusy, a_mdWbValid};
                owr = a_mdWbRd;
            end else begin
                of  = b_fwdE;
                oc  = {b_stallF, b_stallD, b_flushD, b_flushE, b_mdBusy, b_mdWbValid};
                owr = b_mdWbRd;
            end
            cmp(tag, "fwdE",      d, 32'(of),     32'(ef));
            cmp(tag, "stallF",    d, 32'(oc[5]),  32'(haz && !pcSrcE));
            cmp(tag, "stallD",    d, 32'(oc[4]),  32'(haz && !pcSrcE));
            cmp(tag, "flushD",    d, 32'(oc[3]),  32'(pcSrcE));
            cmp(tag, "flushE",    d, 32'(oc[2]),  32'(pcSrcE || haz));
            cmp(tag, "mdBusy",    d, 32'(oc[1]),  32'(m_act[d]));
            cmp(tag, "mdWbValid", d, 32'(oc[0]),  32'(wbv));
            cmp(tag, "mdWbRd",    d, 32'(owr),    wbv ? 32'(m_rd[d]) : 32'd0);
        end
    endtask

    // Model update at the rising edge, using the inputs the DUT samples there.
    task automatic advance();
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_act[d] = 1'b0;
            end else if (m_act[d] && cyc == m_wb_at[d]) begin
                m_act[d] = 1'b0;
            end else if (!m_act[d] && mdStartE) begin
                m_act[d]   = 1'b1;
                m_rd[d]    = rdE;
                m_wb_at[d] = cyc + lat_of(d);
            end
        end
        cyc++;
    endtask

    task automatic sample(input string tag);
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic adv();
        @(posedge clk);
        advance();
        #1;
    endtask

    task automatic clear_inputs();
        rsD = '0; rsE = '0; rdD = '0; rdE = '0; rdM = '0; rdW = '0;
        regWriteD = 0; mdOpD = 0; memReadE = 0; pcSrcE = 0; mdStartE = 0;
        regWriteM = 0; regWriteW = 0;
    endtask

    int wb_a, wb_b;

    initial begin
        ncmp = 0; nfail = 0; cyc = 0;
        for (int d = 0; d < 2; d++) begin
            m_act[d] = 1'b0; m_rd[d] = '0; m_wb_at[d] = 0;
        end
        rst = 1'b0;
        clear_inputs();
        #2 rst = 1'b1;

        // Reset state
        sample("reset"); adv();
        sample("reset"); adv();
        rst = 1'b0;
        sample("idle"); adv();

        // Forwarding priority and per-stage qualification
        rsE = {AW'(5), AW'(5), AW'(5)}; rdM = 5; rdW = 5; regWriteM = 1; regWriteW = 1;
        sample("fwd_m");
        cmp("fwd_m", "lit", 0, 32'(a_fwdE), 32'b1010);
        cmp("fwd_m", "lit", 1, 32'(b_fwdE), 32'b101010);
        adv();
        regWriteM = 0;
        sample("fwd_w");
        cmp("fwd_w", "lit", 0, 32'(a_fwdE), 32'b0101);
        cmp("fwd_w", "lit", 1, 32'(b_fwdE), 32'b010101);
        adv();
        rdW = 0;
        sample("fwd_rf");
        cmp("fwd_rf", "lit", 0, 32'(a_fwdE), 32'b0000);
        cmp("fwd_rf", "lit", 1, 32'(b_fwdE), 32'b000000);
        adv();

        // Load-use, then branch override
        clear_inputs();
        memReadE = 1; rdE = 7; rsD[1] = 7;
        sample("load_use");
        cmp("load_use", "lit", 0, 32'({a_stallF, a_stallD, a_flushD, a_flushE}), 32'b1101);
        adv();
        pcSrcE = 1;
        sample("branch");
        cmp("branch", "lit", 0, 32'({a_stallF, a_stallD, a_flushD, a_flushE}), 32'b0011);
        adv();

        // Multi-cycle latency and dependent stall
        clear_inputs();
        mdStartE = 1; rdE = 9; rsD[0] = 9;
        wb_a = 0; wb_b = 0;
        for (int k = 0; k <= 6; k++) begin
            sample("md_lat");
            cmp("md_lat_stall", "lit", 0, 32'(a_stallD),    32'(k <= 4));
            cmp("md_lat_stall", "lit", 1, 32'(b_stallD),    32'(k <= 2));
            cmp("md_lat_wb",    "lit", 0, 32'(a_mdWbValid), 32'(k == 4));
            cmp("md_lat_wb",    "lit", 1, 32'(b_mdWbValid), 32'(k == 2));
            if (a_mdWbValid) cmp("md_lat_rd", "lit", 0, 32'(a_mdWbRd), 32'd9);
            adv();
            mdStartE = 0; rdE = 0;
        end

        // Structural: mdOpD while busy, start while busy ignored
        clear_inputs();
        mdStartE = 1; rdE = 3;
        sample("md_struct"); adv();
        mdStartE = 0; rdE = 0; mdOpD = 1;
        wb_a = 0; wb_b = 0;
        for (int k = 1; k <= 7; k++) begin
            if (k == 1) begin mdStartE = 1; rdE = 4; end
            else begin mdStartE = 0; rdE = 0; end
            sample("md_struct");
            cmp("md_struct_stall", "lit", 0, 32'(a_stallD), 32'(k <= 4));
            cmp("md_struct_stall", "lit", 1, 32'(b_stallD), 32'(k <= 2));
            if (a_mdWbValid) wb_a++;
            if (b_mdWbValid) wb_b++;
            adv();
        end
        cmp("md_struct_wbcount", "lit", 0, 32'(wb_a), 32'd1);
        cmp("md_struct_wbcount", "lit", 1, 32'(wb_b), 32'd1);

        // Reset in the middle of an op
        clear_inputs();
        rsD[0] = 9; mdStartE = 1; rdE = 9;
        sample("md_rst"); adv();
        mdStartE = 0; rdE = 0;
        sample("md_rst"); adv();
        rst = 1;
        #1;
        cmp("md_rst_busy", "lit", 0, 32'(a_mdBusy), 32'd0);
        cmp("md_rst_wb",   "lit", 1, 32'(b_mdWbValid), 32'd0);
        sample("md_rst"); adv();
        rst = 0;
        wb_a = 0; wb_b = 0;
        for (int k = 0; k < 5; k++) begin
            sample("md_rst_after");
            cmp("md_rst_stall", "lit", 0, 32'(a_stallD), 32'd0);
            if (a_mdWbValid) wb_a++;
            if (b_mdWbValid) wb_b++;
            adv();
        end
        cmp("md_rst_wbcount", "lit", 0, 32'(wb_a), 32'd0);
        cmp("md_rst_wbcount", "lit", 1, 32'(wb_b), 32'd0);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            for (int j = 0; j < 3; j++) begin
                rsD[j] = AW'($urandom_range(0, 3));
                rsE[j] = AW'($urandom_range(0, 3));
            end
            rdD       = AW'($urandom_range(0, 3));
            rdE       = AW'($urandom_range(0, 3));
            rdM       = AW'($urandom_range(0, 3));
            rdW       = AW'($urandom_range(0, 3));
            regWriteD = 1'($urandom_range(0, 1));
            mdOpD     = ($urandom_range(0, 3) == 0);
            memReadE  = ($urandom_range(0, 2) == 0);
            pcSrcE    = ($urandom_range(0, 5) == 0);
            mdStartE  = ($urandom_range(0, 4) == 0);
            regWriteM = 1'($urandom_range(0, 1));
            regWriteW = 1'($urandom_range(0, 1));
            rst       = ($urandom_range(0, 49) == 0);
            sample("random");
            adv();
        end
        rst = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
